// File: rtl/vpu_pkg.sv
// ============================================================================
// Module      : vpu_pkg
// Description : Shared VPU widths and the writeback entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vpu_pkg;

  localparam int OPERAND_WIDTH = 32;
  localparam int DST_IDX_WIDTH = 5;

  typedef struct packed {
    logic [DST_IDX_WIDTH-1:0] dst;
    logic [OPERAND_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/sal_fifo.sv
// ============================================================================
// Module      : sal_fifo
// Description : Synchronous FIFO, 2**DEPTH_LG2 entries, combinational or
//               registered head output (RDATA_FF_OUT).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sal_fifo #(
  parameter int DEPTH_LG2    = 1,
  parameter int WIDTH        = 8,
  parameter int RDATA_FF_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int c_depth = 1 << DEPTH_LG2;

  logic [WIDTH-1:0]   r_mem [c_depth];
  logic [DEPTH_LG2:0] r_wptr;
  logic [DEPTH_LG2:0] r_rptr;
  logic [DEPTH_LG2:0] w_rptr_nxt;
  logic               w_push;
  logic               w_pop;

  assign empty      = (r_wptr == r_rptr);
  assign full       = (r_wptr[DEPTH_LG2-1:0] == r_rptr[DEPTH_LG2-1:0]) &&
                      (r_wptr[DEPTH_LG2] != r_rptr[DEPTH_LG2]);
  assign w_pop      = pop && !empty;
  assign w_push     = push && (!full || w_pop);
  assign w_rptr_nxt = r_rptr + {{DEPTH_LG2{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[DEPTH_LG2-1:0]] <= wdata;
        r_wptr <= r_wptr + 1'b1;
      end
      r_rptr <= w_rptr_nxt;
    end
  end

  generate
    if (RDATA_FF_OUT != 0) begin : g_ff_out
      logic [WIDTH-1:0] r_rdata;
      // Preload the next head; bypass the write when it lands in the head slot.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdata <= '0;
        end else if (w_push && (r_wptr[DEPTH_LG2-1:0] == w_rptr_nxt[DEPTH_LG2-1:0])) begin
          r_rdata <= wdata;
        end else begin
          r_rdata <= r_mem[w_rptr_nxt[DEPTH_LG2-1:0]];
        end
      end
      assign rdata = r_rdata;
    end else begin : g_comb_out
      assign rdata = r_mem[r_rptr[DEPTH_LG2-1:0]];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vpu_result_collector.sv
// ============================================================================
// Module      : vpu_result_collector
// Description : Pairs FU results with issue-time dst tags and buffers them for
//               valid/ready writeback; credit counter gates issue.
//               Optional checking: VPU_RESULT_COLLECTOR_ERR_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vpu_result_collector
  import vpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_i,
  input  logic [DST_IDX_WIDTH-1:0] issue_dst_i,
  output logic                     issue_ready_o,
  input  logic                     done_i,
  input  logic [OPERAND_WIDTH-1:0] result_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [OPERAND_WIDTH-1:0] wb_data_o,
  output logic [DST_IDX_WIDTH-1:0] wb_dst_o,
  output logic                     err_o
);

  localparam int                 c_depth_lg2 = $clog2(DEPTH);
  localparam int                 c_cnt_w     = c_depth_lg2 + 1;
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

  logic [c_cnt_w-1:0]       r_cnt;
  logic [DST_IDX_WIDTH-1:0] w_tag_head;
  logic                     w_tag_empty;
  logic                     w_tag_full;
  logic                     w_res_empty;
  logic                     w_res_full;
  logic                     w_issue_acc;
  logic                     w_wb_hs;
  logic                     w_done_acc;
  wb_entry_t                w_res_in;
  wb_entry_t                w_res_head;

  assign issue_ready_o = (r_cnt < c_depth_cnt);
  assign w_issue_acc   = issue_i && issue_ready_o;
  assign wb_valid_o    = !w_res_empty;
  assign w_wb_hs       = wb_valid_o && wb_ready_i;
  // Results with no outstanding tag (e.g. in flight across a reset) are dropped.
  assign w_done_acc    = done_i && !w_tag_empty;
  assign w_res_in      = '{dst: w_tag_head, data: result_i};
  assign wb_data_o     = w_res_head.data;
  assign wb_dst_o      = w_res_head.dst;

  sal_fifo #(
    .DEPTH_LG2   (c_depth_lg2),
    .WIDTH       (DST_IDX_WIDTH),
    .RDATA_FF_OUT(0)
  ) u_tag_q (
    .clk  (clk),
    .rst  (rst),
    .push (w_issue_acc),
    .wdata(issue_dst_i),
    .pop  (w_done_acc),
    .rdata(w_tag_head),
    .empty(w_tag_empty),
    .full (w_tag_full)
  );

  sal_fifo #(
    .DEPTH_LG2   (c_depth_lg2),
    .WIDTH       ($bits(wb_entry_t)),
    .RDATA_FF_OUT(1)
  ) u_res_q (
    .clk  (clk),
    .rst  (rst),
    .push (w_done_acc),
    .wdata(w_res_in),
    .pop  (w_wb_hs),
    .rdata(w_res_head),
    .empty(w_res_empty),
    .full (w_res_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_issue_acc && !w_wb_hs) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (!w_issue_acc && w_wb_hs) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

`ifdef VPU_RESULT_COLLECTOR_ERR_CHK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((issue_i && !issue_ready_o) || (done_i && w_tag_empty)) begin
      r_err <= 1'b1;
    end
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  logic w_unused;
  assign w_unused = w_tag_full ^ w_res_full;

endmodule

`default_nettype wire

// File: tb/tb_vpu_result_collector.sv
// ============================================================================
// Module      : tb_vpu_result_collector
// Description : Directed self-checking bench for vpu_result_collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vpu_result_collector;
  import vpu_pkg::*;

`ifdef VPU_RESULT_COLLECTOR_ERR_CHK_EN
  localparam logic c_err_en = 1'b1;
`else
  localparam logic c_err_en = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     issue_i;
  logic [DST_IDX_WIDTH-1:0] issue_dst_i;
  logic                     issue_ready_o;
  logic                     done_i;
  logic [OPERAND_WIDTH-1:0] result_i;
  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [OPERAND_WIDTH-1:0] wb_data_o;
  logic [DST_IDX_WIDTH-1:0] wb_dst_o;
  logic                     err_o;

  int n_cmp = 0;
  int n_bad = 0;

  vpu_result_collector #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (issue_i),
    .issue_dst_i  (issue_dst_i),
    .issue_ready_o(issue_ready_o),
    .done_i       (done_i),
    .result_i     (result_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_data_o    (wb_data_o),
    .wb_dst_o     (wb_dst_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; issue_i = 1'b0; issue_dst_i = '0; done_i = 1'b0;
    result_i = '0; wb_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_wb_dst", wb_dst_o, 0);
    chk("rst_err", err_o, 0);

    // Single op: issue dst 3, result five cycles later
    issue_i = 1'b1; issue_dst_i = 5'd3;
    tick();
    issue_i = 1'b0;
    chk("t1_ready_after_issue", issue_ready_o, 1);
    repeat (4) tick();
    done_i = 1'b1; result_i = 32'h3F80_0000; wb_ready_i = 1'b1;
    chk("t1_valid_before_done", wb_valid_o, 0);
    tick();
    done_i = 1'b0;
    chk("t1_valid", wb_valid_o, 1);
    chk("t1_dst", wb_dst_o, 3);
    chk("t1_data", wb_data_o, 32'h3F80_0000);
    chk("t1_ready", issue_ready_o, 1);
    tick();
    chk("t1_valid_after_pop", wb_valid_o, 0);
    chk("t1_ready_after_pop", issue_ready_o, 1);
    chk("t1_err", err_o, 0);

    // Fill credits, third issue rejected, buffer two results under stall
    wb_ready_i = 1'b0;
    issue_i = 1'b1; issue_dst_i = 5'd1;
    tick();
    issue_dst_i = 5'd2;
    tick();
    chk("t2_ready_full", issue_ready_o, 0);
    issue_dst_i = 5'd7;
    tick();
    issue_i = 1'b0;
    chk("t2_ready_still_full", issue_ready_o, 0);
    chk("t2_err_after_reject", err_o, c_err_en);
    done_i = 1'b1; result_i = 32'h0000_000A;
    tick();
    chk("t2_valid", wb_valid_o, 1);
    chk("t2_dst_first", wb_dst_o, 1);
    chk("t2_data_first", wb_data_o, 32'h0000_000A);
    result_i = 32'h0000_000B;
    tick();
    done_i = 1'b0; result_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall_valid", wb_valid_o, 1);
      chk("t3_stall_dst", wb_dst_o, 1);
      chk("t3_stall_data", wb_data_o, 32'h0000_000A);
      chk("t3_stall_ready", issue_ready_o, 0);
      tick();
    end
    wb_ready_i = 1'b1;
    tick();
    chk("t3_second_valid", wb_valid_o, 1);
    chk("t3_second_dst", wb_dst_o, 2);
    chk("t3_second_data", wb_data_o, 32'h0000_000B);
    chk("t3_ready_after_pop1", issue_ready_o, 1);
    tick();
    chk("t3_empty", wb_valid_o, 0);
    chk("t3_ready_after_pop2", issue_ready_o, 1);

    // Rejected dst 7 must never have been queued: a stray done is dropped
    done_i = 1'b1; result_i = 32'h1234_5678;
    tick();
    done_i = 1'b0;
    chk("t3_orphan_dropped", wb_valid_o, 0);

    // Simultaneous issue and handshake at cnt=1 leaves cnt at 1
    issue_i = 1'b1; issue_dst_i = 5'd4;
    tick();
    issue_i = 1'b0;
    done_i = 1'b1; result_i = 32'h0000_000C;
    tick();
    done_i = 1'b0;
    chk("t4_valid", wb_valid_o, 1);
    chk("t4_dst", wb_dst_o, 4);
    issue_i = 1'b1; issue_dst_i = 5'd5;
    tick();
    chk("t4_ready_same", issue_ready_o, 1);
    chk("t4_popped", wb_valid_o, 0);
    issue_dst_i = 5'd6;
    tick();
    issue_i = 1'b0;
    chk("t4_cnt_was_one", issue_ready_o, 0);

    // Two entries buffered, then reset mid-operation
    wb_ready_i = 1'b0;
    done_i = 1'b1; result_i = 32'h0000_000D;
    tick();
    result_i = 32'h0000_000E;
    tick();
    done_i = 1'b0;
    chk("t5_buffered_dst", wb_dst_o, 5);
    chk("t5_buffered_data", wb_data_o, 32'h0000_000D);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", wb_valid_o, 0);
    chk("t5_rst_ready", issue_ready_o, 1);
    chk("t5_rst_data", wb_data_o, 0);
    chk("t5_rst_err", err_o, 0);
    wb_ready_i = 1'b1;
    done_i = 1'b1; result_i = 32'h0000_00FF;
    tick();
    done_i = 1'b0;
    chk("t5_late_done_dropped", wb_valid_o, 0);
    chk("t5_late_done_err", err_o, c_err_en);
    tick();
    chk("t5_still_empty", wb_valid_o, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_err_cleared", err_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
